// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic definitions: FSM encodings, default width and the MIN constant helper.
// Imported by the divider and by arithmetic testbenches.
package seq_signed_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ITER  = 2'd2;
    localparam logic [1:0] ST_FIXUP = 2'd3;

    function automatic logic [DEFAULT_WIDTH-1:0] min_value();
        return {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bus of the sequential signed divider.
interface seq_signed_divider_if #(parameter int WIDTH = 32);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_signed_divider_nr_div_step.sv
// One radix-2 non-restoring division step on magnitudes.
// P is WIDTH+1 bits signed; the add/subtract choice follows the sign of P before the shift.
module nr_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] p_sh;
    logic [WIDTH:0] d_ext;

    always_comb begin
        p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
        d_ext  = {1'b0, d};
        p_next = p[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
        q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: one non-restoring iteration per clock on operand magnitudes,
// signs re-applied in a final fix-up cycle. Truncating division, remainder follows dividend.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; also holds the done cycle (busy still high)
//   ST_LOAD  | latch signs and magnitudes, clear partial remainder
//   ST_ITER  | WIDTH shift/add-subtract steps, counter WIDTH-1 down to 0
//   ST_FIXUP | restore negative remainder, apply signs, register results, pulse done
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rem_mag;

    function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .q      (q),
        .d      (d),
        .p_next (p_next),
        .q_next (q_next)
    );

    // A negative final partial remainder is one subtraction too far.
    always_comb begin
        rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            p               <= '0;
            q               <= '0;
            d               <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy is still high during the done cycle, so a start there is refused
                    if (bus.busy) begin
                        bus.busy <= 1'b0;
                    end else if (bus.start) begin
                        q        <= bus.dividend;
                        d        <= bus.divisor;
                        bus.busy <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    neg_r <= q[WIDTH-1];
                    neg_q <= q[WIDTH-1] ^ d[WIDTH-1];
                    dz    <= (d == '0);
                    q     <= q[WIDTH-1] ? twos(q) : q;
                    d     <= d[WIDTH-1] ? twos(d) : d;
                    p     <= '0;
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    p <= p_next;
                    q <= q_next;
                    if (cnt == '0) begin
                        state <= ST_FIXUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIXUP: begin
                    // With a zero divisor the iteration leaves Q all ones and P = |dividend|.
                    bus.quotient    <= dz ? '1 : (neg_q ? twos(q) : q);
                    bus.remainder   <= neg_r ? twos(rem_mag) : rem_mag;
                    bus.div_by_zero <= dz;
                    bus.done        <= 1'b1;
                    state           <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed vector table, handshake corner
// sequences, and random signed pairs against a truncating-division reference model.
module tb_seq_signed_divider;
    import seq_signed_divider_pkg::*;

    localparam int W      = 32;
    localparam int LAT    = W + 2;
    localparam int N_RAND = 200;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dz;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_signed_divider_if #(.WIDTH(W)) bus ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 100);
        if (!bus.done) lat = -1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
        @(posedge clk);
        #1;
    endtask

    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (a == min_value() && b == '1) begin
            q = min_value();
            r = '0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    vec_t         vecs[$];
    logic [W-1:0] q, r, eq, er;
    logic         dz, edz;
    int           lat;
    int           cnt_seen;
    logic [W-1:0] MINV, MAXV;

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        MINV         = min_value();
        MAXV         = ~min_value();

        vecs.push_back('{32'd100,          32'd7,          32'd14,         32'd2,          1'b0});
        vecs.push_back('{-32'sd100,        32'd7,          32'hFFFF_FFF2,  -32'sd2,        1'b0});
        vecs.push_back('{32'd100,          -32'sd7,        -32'sd14,       32'd2,          1'b0});
        vecs.push_back('{-32'sd100,        -32'sd7,        32'd14,         -32'sd2,        1'b0});
        vecs.push_back('{32'd7,            32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1});
        vecs.push_back('{-32'sd1,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1});
        vecs.push_back('{MINV,             32'hFFFF_FFFF,  MINV,           32'd0,          1'b0});
        vecs.push_back('{MINV,             32'd1,          MINV,           32'd0,          1'b0});
        vecs.push_back('{MINV,             MINV,           32'd1,          32'd0,          1'b0});
        vecs.push_back('{MINV,             MAXV,           32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0});
        vecs.push_back('{MAXV,             MINV,           32'd0,          MAXV,           1'b0});
        vecs.push_back('{32'd0,            32'd5,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{-32'sd5,          32'd9,          32'd0,          -32'sd5,        1'b0});
        vecs.push_back('{32'd7,            32'd7,          32'd1,          32'd0,          1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient",  bus.quotient, '0);
        chk("reset_remainder", bus.remainder, '0);
        chk("reset_busy",      W'(bus.busy), '0);
        chk("reset_done",      W'(bus.done), '0);
        chk("reset_dz",        W'(bus.div_by_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dz, lat);
            chk($sformatf("vec%0d_quotient", i),  q, vecs[i].exp_q);
            chk($sformatf("vec%0d_remainder", i), r, vecs[i].exp_r);
            chk($sformatf("vec%0d_dz", i),        W'(dz), W'(vecs[i].exp_dz));
            chk($sformatf("vec%0d_latency", i),   W'(lat), W'(LAT));
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", W'(bus.busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
        end while (!bus.done && lat < 100);
        chk("busy_ignore_latency",   W'(lat), W'(LAT));
        chk("busy_ignore_quotient",  bus.quotient, 32'd14);
        chk("busy_ignore_remainder", bus.remainder, 32'd2);
        cnt_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.done) cnt_seen++;
        end
        chk("busy_ignore_no_restart", W'(cnt_seen), 32'd0);

        // start during the done cycle is refused, accepted one cycle later
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("done_cycle_first_quotient", bus.quotient, 32'd14);
        chk("done_cycle_busy_high",      W'(bus.busy), 32'd1);
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd2;
        @(posedge clk);
        #1;
        chk("done_cycle_start_refused", W'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("restart_accepted", W'(bus.busy), 32'd1);
        wait_done(lat);
        chk("restart_latency",   W'(lat), W'(LAT));
        chk("restart_quotient",  bus.quotient, 32'd4);
        chk("restart_remainder", bus.remainder, 32'd1);
        @(posedge clk);
        #1;

        // reset in the middle of an operation
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient",  bus.quotient, '0);
        chk("midrst_remainder", bus.remainder, '0);
        chk("midrst_busy",      W'(bus.busy), '0);
        chk("midrst_done",      W'(bus.done), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) cnt_seen++;
        end
        chk("midrst_no_done", W'(cnt_seen), 32'd0);
        run_op(32'd100, -32'sd7, q, r, dz, lat);
        chk("postrst_quotient",  q, -32'sd14);
        chk("postrst_remainder", r, 32'd2);
        chk("postrst_latency",   W'(lat), W'(LAT));

        // random signed pairs against the reference model
        for (int i = 0; i < N_RAND; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            if (i % 4 == 0) b = W'(int'($urandom_range(20)) - 10);
            else if (i % 4 == 1) b = W'($urandom_range(1000));
            else b = $urandom;
            if (i % 8 == 3) a = W'(int'($urandom_range(200)) - 100);
            ref_div(a, b, eq, er, edz);
            run_op(a, b, q, r, dz, lat);
            chk($sformatf("rand%0d_quotient 0x%08h/0x%08h", i, a, b), q, eq);
            chk($sformatf("rand%0d_remainder", i), r, er);
            chk($sformatf("rand%0d_dz", i), W'(dz), W'(edz));
            chk($sformatf("rand%0d_latency", i), W'(lat), W'(LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
